win3x3_line_buffer: RTL and testbench

- Streaming 3x3 neighbourhood generator for the sharpening pipeline.
- Replaces the full-frame 9-port combinational input memory with two on-chip line buffers plus a 3x3 window register.
- Accepts pixels in raster order over a valid/ready handshake and emits one 3x3 window per pixel, centred on that pixel, in raster order.
- Image size, pixel width and border policy are parameters.

---
 rtl/win3x3_line_buffer.sv | 166 ++++++++++++++++
 tb/tb_win3x3_line_buffer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/win3x3_line_buffer.sv
// Streaming 3x3 window generator: two line buffers feed a two-column shift register, borders applied as each window is registered.
// Latency: window (x,y) is valid the cycle after pixel (x+1,y+1) is accepted; input stalls while the output register is held.
module win3x3_line_buffer #(
  parameter int IMG_W       = 800,
  parameter int IMG_H       = 600,
  parameter int PIX_W       = 8,
  parameter int BORDER_MODE = 0,
  localparam int XW = $clog2(IMG_W),
  localparam int YW = $clog2(IMG_H)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   in_pix,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [9*PIX_W-1:0] out_win,
  output logic [XW-1:0]      out_x,
  output logic [YW-1:0]      out_y,
  output logic               out_last
);

  localparam int XW1 = XW + 1;
  localparam int YW1 = YW + 1;
  localparam int CW  = 3 * PIX_W;
  localparam logic [XW-1:0] X_MAX  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(IMG_H - 1);
  localparam logic [YW:0]   Y_END  = YW1'(IMG_H);
  localparam logic [XW:0]   DC_END = XW1'(IMG_W);

  typedef enum logic [1:0] {FILL, RUN, EOL, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [XW-1:0]    in_x;
  logic [YW:0]      in_y;
  logic [XW:0]      dc;
  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  // Columns are packed {bottom, middle, top}; col_a is one column older than col_b.
  logic [CW-1:0]    col_a, col_b, new_col, cl, cr;
  logic [XW-1:0]    rd_idx;
  logic             acc, out_free, shift, load;
  logic [XW-1:0]    ld_x;
  logic [YW-1:0]    ld_y;
  logic [9*PIX_W-1:0] win_ld;

  assign out_free = !out_valid || out_ready;
  assign in_ready = !rst && (state_q == FILL || state_q == RUN) && out_free;
  assign acc      = in_valid && in_ready;

  always_comb begin
    rd_idx = in_x;
    if (state_q == EOL) rd_idx = '0;
    else if (state_q == DRAIN) rd_idx = dc[XW-1:0];
    new_col = {in_pix, lb1[rd_idx], lb0[rd_idx]};
  end

  always_comb begin
    state_d = state_q;
    shift   = 1'b0;
    load    = 1'b0;
    ld_x    = in_x - XW'(1);
    ld_y    = YW'(in_y - YW1'(1));
    case (state_q)
      FILL: begin
        shift = acc;
        if (acc && in_x == '0 && in_y == YW1'(1)) state_d = RUN;
      end
      RUN: begin
        shift = acc;
        load  = acc && (in_x != '0);
        if (acc && in_x == X_MAX) state_d = EOL;
      end
      EOL: begin
        ld_x = X_MAX;
        ld_y = YW'(in_y - YW1'(2));
        if (out_free) begin
          load = 1'b1;
          if (in_y == Y_END) begin
            // Prime column 0 of the last two rows so the drain starts at full rate.
            shift   = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = RUN;
          end
        end
      end
      DRAIN: begin
        ld_x = XW'(dc - XW1'(1));
        ld_y = Y_MAX;
        if (dc <= DC_END && out_free) begin
          load  = 1'b1;
          shift = (dc != DC_END);
        end
        if (dc > DC_END && out_valid && out_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    cl = col_a;
    cr = new_col;
    if (ld_x == '0)   cl = (BORDER_MODE == 1) ? col_b : '0;
    if (ld_x == X_MAX) cr = (BORDER_MODE == 1) ? col_b : '0;
    win_ld = {cr[2*PIX_W +: PIX_W], col_b[2*PIX_W +: PIX_W], cl[2*PIX_W +: PIX_W],
              cr[PIX_W +: PIX_W],   col_b[PIX_W +: PIX_W],   cl[PIX_W +: PIX_W],
              cr[0 +: PIX_W],       col_b[0 +: PIX_W],       cl[0 +: PIX_W]};
    // Rows after columns so replicated corners pick up the clamped centre column.
    if (ld_y == '0)    win_ld[0 +: CW]    = (BORDER_MODE == 1) ? win_ld[CW +: CW] : '0;
    if (ld_y == Y_MAX) win_ld[2*CW +: CW] = (BORDER_MODE == 1) ? win_ld[CW +: CW] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      in_x      <= '0;
      in_y      <= '0;
      dc        <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_win   <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        if (in_x == X_MAX) begin
          in_x <= '0;
          in_y <= in_y + YW1'(1);
        end else begin
          in_x <= in_x + XW'(1);
        end
      end
      if (state_q == EOL && state_d == DRAIN) dc <= XW1'(1);
      else if (state_q == DRAIN && load) dc <= dc + XW1'(1);
      if (state_q == DRAIN && state_d == FILL) begin
        in_y <= '0;
        dc   <= '0;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_win   <= win_ld;
        out_x     <= ld_x;
        out_y     <= ld_y;
        out_last  <= (ld_x == X_MAX) && (ld_y == Y_MAX);
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      lb0[in_x] <= lb1[in_x];
      lb1[in_x] <= in_pix;
    end
    if (shift) begin
      col_a <= col_b;
      col_b <= new_col;
    end
  end

endmodule

// File: tb/tb_win3x3_line_buffer.sv
// Bench for win3x3_line_buffer: mode 0 and mode 1 instances share one stream, checked against a coordinate-level model.
module tb_win3x3_line_buffer;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int P     = 8;
  localparam int N     = W * H;
  localparam int BOUND = 2000;

  typedef struct packed {
    logic [9*P-1:0] win;
    logic [1:0]     x;
    logic [1:0]     y;
    logic           last;
  } rec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b1;
  logic [P-1:0]   in_pix = '0;
  logic           in_ready0, in_ready1, out_valid0, out_valid1, out_last0, out_last1;
  logic [9*P-1:0] out_win0, out_win1;
  logic [1:0]     out_x0, out_x1, out_y0, out_y1;

  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   first_vcyc = -1;
  int   frames [3][N];
  int   tx_q[$];
  int   acc_cyc[$];
  int   cap_cyc[$];
  bit   rdy_cap[$];
  rec_t cap0[$];
  rec_t cap1[$];

  always #5 clk = ~clk;

  win3x3_line_buffer #(.IMG_W(W), .IMG_H(H), .PIX_W(P), .BORDER_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_pix(in_pix),
    .out_valid(out_valid0), .out_ready(out_ready), .out_win(out_win0),
    .out_x(out_x0), .out_y(out_y0), .out_last(out_last0));

  win3x3_line_buffer #(.IMG_W(W), .IMG_H(H), .PIX_W(P), .BORDER_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_pix(in_pix),
    .out_valid(out_valid1), .out_ready(out_ready), .out_win(out_win1),
    .out_x(out_x1), .out_y(out_y1), .out_last(out_last1));

  function automatic logic [9*P-1:0] model_win(input int f, input int x, input int y, input int mode);
    logic [9*P-1:0] w;
    int nx, ny;
    bit outside;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      nx = x + (k % 3) - 1;
      ny = y + (k / 3) - 1;
      outside = (nx < 0) || (nx >= W) || (ny < 0) || (ny >= H);
      if (!outside || mode == 1) begin
        nx = (nx < 0) ? 0 : ((nx >= W) ? W - 1 : nx);
        ny = (ny < 0) ? 0 : ((ny >= H) ? H - 1 : ny);
        w[k*P +: P] = P'(frames[f][ny*W + nx]);
      end
    end
    return w;
  endfunction

  function automatic rec_t model_rec(input int f, input int k, input int mode);
    rec_t r;
    r.win  = model_win(f, k % W, k / W, mode);
    r.x    = 2'(k % W);
    r.y    = 2'(k / W);
    r.last = (k == N - 1);
    return r;
  endfunction

  function automatic logic [9*P-1:0] pk(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7,
                                        input int a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic stream(input int n_win, input bit rnd);
    int   cyc = 0;
    bit   hold0 = 1'b0;
    bit   hold1 = 1'b0;
    rec_t r0, r1, prev0, prev1;
    while ((tx_q.size() > 0 || cap0.size() < n_win) && cyc < BOUND) begin
      @(posedge clk);
      #1;
      in_valid  = (tx_q.size() > 0) && (!rnd || ($urandom_range(0, 1) == 1));
      in_pix    = (tx_q.size() > 0) ? P'(tx_q[0]) : '0;
      out_ready = !rnd || ($urandom_range(0, 1) == 1);
      @(negedge clk);
      cyc++;
      cycle++;
      r0 = {out_win0, out_x0, out_y0, out_last0};
      r1 = {out_win1, out_x1, out_y1, out_last1};
      if (hold0) chk("hold m0", {out_valid0, r0}, {1'b1, prev0});
      if (hold1) chk("hold m1", {out_valid1, r1}, {1'b1, prev1});
      hold0 = out_valid0 && !out_ready;
      hold1 = out_valid1 && !out_ready;
      prev0 = r0;
      prev1 = r1;
      if (in_valid && in_ready0) begin
        acc_cyc.push_back(cycle);
        void'(tx_q.pop_front());
      end
      if (out_valid0 && first_vcyc < 0) first_vcyc = cycle;
      if (out_valid0 && out_ready) begin
        cap0.push_back(r0);
        cap_cyc.push_back(cycle);
        rdy_cap.push_back(in_ready0);
      end
      if (out_valid1 && out_ready) cap1.push_back(r1);
    end
    chk("stream bound", cyc < BOUND, 1);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic clear_caps();
    cap0.delete();
    cap1.delete();
    cap_cyc.delete();
    rdy_cap.delete();
    acc_cyc.delete();
  endtask

  task automatic check_seq(input string tag, input int nf);
    chk({tag, " count m0"}, cap0.size(), nf * N);
    chk({tag, " count m1"}, cap1.size(), nf * N);
    for (int i = 0; i < nf * N && i < cap0.size(); i++)
      chk($sformatf("%s m0 win%0d", tag, i), cap0[i], model_rec(i / N, i % N, 0));
    for (int i = 0; i < nf * N && i < cap1.size(); i++)
      chk($sformatf("%s m1 win%0d", tag, i), cap1[i], model_rec(i / N, i % N, 1));
  endtask

  task automatic load_frame(input int f, input int count);
    for (int i = 0; i < count; i++) tx_q.push_back(frames[f][i]);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      frames[0][i] = i + 1;
      frames[1][i] = 100 + i + 1;
      frames[2][i] = int'($urandom_range(0, 255));
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", in_ready0, 0);
    chk("rst out_valid", {out_valid0, out_valid1}, 0);
    chk("rst out_last", {out_last0, out_last1}, 0);
    chk("rst out_win", out_win0, 0);
    chk("rst out_xy", {out_x0, out_y0}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("fill in_ready", in_ready0, 1);

    // Three frames back to back, continuous, no backpressure
    clear_caps();
    first_vcyc = -1;
    load_frame(0, N);
    load_frame(1, N);
    load_frame(2, N);
    stream(3 * N, 1'b0);
    idle();
    check_seq("b2b", 3);
    chk("accept count", acc_cyc.size(), 3 * N);
    if (acc_cyc.size() == 3 * N && cap0.size() >= N) begin
      chk("first out_valid", first_vcyc, acc_cyc[5] + 1);
      for (int i = 0; i < N - 1; i++)
        chk($sformatf("accept gap %0d", i), acc_cyc[i+1] - acc_cyc[i], (i == 7) ? 2 : 1);
      for (int i = 2 * W; i < N; i++)
        chk($sformatf("drain in_ready %0d", i), rdy_cap[i], 0);
      chk("next frame after last", acc_cyc[N] > cap_cyc[N-1], 1);
    end
    if (cap0.size() >= 2 * N && cap1.size() >= N) begin
      chk("m0 win(0,0)", cap0[0].win, pk(0, 0, 0, 0, 1, 2, 0, 5, 6));
      chk("m0 win(1,1)", cap0[5].win, pk(1, 2, 3, 5, 6, 7, 9, 10, 11));
      chk("m0 win(3,2)", {cap0[N-1].win, cap0[N-1].last}, {pk(7, 8, 0, 11, 12, 0, 0, 0, 0), 1'b1});
      chk("m1 win(0,0)", cap1[0].win, pk(1, 1, 2, 1, 1, 2, 5, 5, 6));
      chk("m1 win(3,2)", cap1[N-1].win, pk(7, 8, 8, 11, 12, 12, 11, 12, 12));
      chk("m0 f2 win(0,0)", cap0[N].win, pk(0, 0, 0, 0, 101, 102, 0, 105, 106));
    end

    // Random input gaps and output backpressure
    clear_caps();
    load_frame(0, N);
    stream(N, 1'b1);
    idle();
    check_seq("bp", 1);

    // Reset after 7 pixels, then a full clean frame
    clear_caps();
    load_frame(0, 7);
    stream(0, 1'b0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid rst in_ready", in_ready0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post rst out_valid", {out_valid0, out_valid1}, 0);
    chk("post rst in_ready", in_ready0, 1);
    clear_caps();
    load_frame(0, N);
    stream(N, 1'b0);
    idle();
    check_seq("rst", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
